// File: rtl/coeff_bank_loader.sv
// rtl/coeff_bank_loader.sv - FIR coefficient bank load sequencer for the three-axis signal path
// Optional stall timeout in LOAD: define LOADER_TIMEOUT_EN.
module coeff_bank_loader #(
    parameter logic [1:0] DEFAULT_BANK   = 2'd0,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_axis,
    input  logic [1:0]  cmd_bank,
    input  logic        cmd_activate,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [15:0] wr_data,
    input  logic        path_available,
    output logic        update_en,
    output logic [1:0]  update_axis,
    output logic [1:0]  update_bank,
    output logic [3:0]  update_index,
    output logic [15:0] update_value,
    output logic [1:0]  x_bank,
    output logic [1:0]  y_bank,
    output logic [1:0]  z_bank,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SWAP,
        S_FINISH
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [1:0]  r_axis;
    logic [1:0]  r_bank;
    logic        r_activate;
    logic [3:0]  r_index;

    logic        r_update_en;
    logic [1:0]  r_update_axis;
    logic [1:0]  r_update_bank;
    logic [3:0]  r_update_index;
    logic [15:0] r_update_value;

    logic [1:0]  r_x_bank;
    logic [1:0]  r_y_bank;
    logic [1:0]  r_z_bank;
    logic        r_error;

    logic        w_cmd_fire;
    logic        w_reject;
    logic        w_accept;
    logic        w_beat;
    logic        w_last_beat;
    logic        w_swap;
    logic        w_timeout;
    logic [1:0]  w_cur_bank;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    assign cmd_ready = (r_state == S_IDLE) && !reset;
    assign wr_ready  = (r_state == S_LOAD) && path_available;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_FINISH);
    assign error     = r_error;

    assign update_en    = r_update_en;
    assign update_axis  = r_update_axis;
    assign update_bank  = r_update_bank;
    assign update_index = r_update_index;
    assign update_value = r_update_value;

    assign x_bank = r_x_bank;
    assign y_bank = r_y_bank;
    assign z_bank = r_z_bank;

    always_comb begin
        w_cur_bank = 2'd0;
        case (cmd_axis)
            2'd1:    w_cur_bank = r_x_bank;
            2'd2:    w_cur_bank = r_y_bank;
            2'd3:    w_cur_bank = r_z_bank;
            default: w_cur_bank = 2'd0;
        endcase
    end

    // Re-loading the bank an axis is currently filtering with would corrupt a live pass.
    assign w_cmd_fire  = cmd_valid && cmd_ready;
    assign w_reject    = w_cmd_fire && ((cmd_axis == 2'd0) || (cmd_bank == w_cur_bank));
    assign w_accept    = w_cmd_fire && !w_reject;
    assign w_beat      = wr_valid && wr_ready;
    assign w_last_beat = w_beat && (r_index == 4'd15);
    assign w_swap      = (r_state == S_SWAP) && path_available;

`ifdef LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_idle_cnt;

    always_ff @(posedge sys_clk) begin
        if (reset || (r_state != S_LOAD) || w_beat) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == S_LOAD) && !w_beat &&
                       (r_idle_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_last_beat) begin
                    w_next_state = r_activate ? S_SWAP : S_FINISH;
                end else if (w_timeout) begin
                    w_next_state = S_IDLE;
                end
            end
            S_SWAP: begin
                if (path_available) begin
                    w_next_state = S_FINISH;
                end
            end
            S_FINISH: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_axis         <= 2'd0;
            r_bank         <= 2'd0;
            r_activate     <= 1'b0;
            r_index        <= 4'd0;
            r_update_en    <= 1'b0;
            r_update_axis  <= 2'd0;
            r_update_bank  <= 2'd0;
            r_update_index <= 4'd0;
            r_update_value <= 16'd0;
            r_x_bank       <= DEFAULT_BANK;
            r_y_bank       <= DEFAULT_BANK;
            r_z_bank       <= DEFAULT_BANK;
            r_error        <= 1'b0;
        end else begin
            r_update_en <= w_beat;
            r_error     <= w_reject || w_timeout;

            if (w_accept) begin
                r_axis     <= cmd_axis;
                r_bank     <= cmd_bank;
                r_activate <= cmd_activate;
                r_index    <= 4'd0;
            end

            if (w_beat) begin
                r_update_axis  <= r_axis;
                r_update_bank  <= r_bank;
                r_update_index <= r_index;
                r_update_value <= wr_data;
                r_index        <= r_index + 4'd1;
            end

            // Only the latched axis switches; the swap waits for an idle path.
            if (w_swap) begin
                case (r_axis)
                    2'd1:    r_x_bank <= r_bank;
                    2'd2:    r_y_bank <= r_bank;
                    2'd3:    r_z_bank <= r_bank;
                    default: r_x_bank <= r_x_bank;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_coeff_bank_loader.sv
// tb/tb_coeff_bank_loader.sv - randomized bench for coeff_bank_loader against a transaction-level model
module tb_coeff_bank_loader;

    logic        sys_clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_axis;
    logic [1:0]  cmd_bank;
    logic        cmd_activate;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_data;
    logic        path_available;
    logic        update_en;
    logic [1:0]  update_axis;
    logic [1:0]  update_bank;
    logic [3:0]  update_index;
    logic [15:0] update_value;
    logic [1:0]  x_bank;
    logic [1:0]  y_bank;
    logic [1:0]  z_bank;
    logic        busy;
    logic        done;
    logic        error;

    coeff_bank_loader dut (
        .sys_clk        (sys_clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_axis       (cmd_axis),
        .cmd_bank       (cmd_bank),
        .cmd_activate   (cmd_activate),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_data        (wr_data),
        .path_available (path_available),
        .update_en      (update_en),
        .update_axis    (update_axis),
        .update_bank    (update_bank),
        .update_index   (update_index),
        .update_value   (update_value),
        .x_bank         (x_bank),
        .y_bank         (y_bank),
        .z_bank         (z_bank),
        .busy           (busy),
        .done           (done),
        .error          (error)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference: phase 0 waiting for a command, 1 collecting words, 2 waiting to switch, 3 reporting done.
    int ph;
    int nwords;
    int m_axis, m_bank, m_act;
    int banks[4];
    int swait;
    int e_en, e_err, e_ax, e_bk, e_ix, e_val;

    // Stimulus knobs
    int cyc;
    int g_cv_pct, g_wv_pct, g_pa_mode;
    int g_fix, g_fax, g_fbk, g_fact;
    int g_seq, g_rst_at7, g_rand_rst;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic model_reset();
        ph = 0; nwords = 0; swait = 0;
        m_axis = 0; m_bank = 0; m_act = 0;
        for (int i = 0; i < 4; i++) banks[i] = 0;
        e_en = 0; e_err = 0; e_ax = 0; e_bk = 0; e_ix = 0; e_val = 0;
    endtask

    task automatic model_step();
        if (reset) begin
            model_reset();
            return;
        end
        e_en  = 0;
        e_err = 0;
        if (ph == 0) begin
            if (cmd_valid) begin
                if (cmd_axis == 0 || int'(cmd_bank) == banks[cmd_axis]) begin
                    e_err = 1;
                end else begin
                    m_axis = cmd_axis; m_bank = cmd_bank; m_act = cmd_activate;
                    nwords = 0;
                    ph = 1;
                end
            end
        end else if (ph == 1) begin
            if (wr_valid && path_available) begin
                e_en = 1; e_ax = m_axis; e_bk = m_bank; e_ix = nwords; e_val = wr_data;
                nwords++;
                if (nwords == 16) ph = m_act ? 2 : 3;
            end
        end else if (ph == 2) begin
            if (path_available) begin
                banks[m_axis] = m_bank;
                ph = 3;
            end
        end else begin
            ph = 0;
        end
        swait = (ph == 2) ? swait + 1 : 0;
    endtask

    task automatic cycle();
        @(negedge sys_clk);
        cyc++;
        reset = 1'b0;
        if (g_rst_at7 != 0 && ph == 1 && nwords == 7) begin
            reset = 1'b1;
            g_rst_at7 = 0;
        end else if (g_rand_rst != 0 && $urandom_range(0, 499) == 0) begin
            reset = 1'b1;
        end
        cmd_valid = ($urandom_range(0, 99) < g_cv_pct);
        if (g_fix != 0) begin
            cmd_axis = 2'(g_fax); cmd_bank = 2'(g_fbk); cmd_activate = g_fact[0];
        end else begin
            cmd_axis = 2'($urandom_range(0, 3));
            cmd_bank = 2'($urandom_range(0, 3));
            cmd_activate = 1'($urandom_range(0, 1));
        end
        wr_valid = ($urandom_range(0, 99) < g_wv_pct);
        wr_data  = (g_seq != 0) ? 16'(16'h0100 + nwords) : 16'($urandom);
        case (g_pa_mode)
            1:       path_available = 1'b1;
            2:       path_available = cyc[0];
            3:       path_available = !(ph == 2 && swait < 20);
            default: path_available = ($urandom_range(0, 99) < 75);
        endcase
        #1;
        if (reset) begin
            check("cmd_ready_in_reset", cmd_ready, 0);
        end else begin
            check("cmd_ready", cmd_ready, ph == 0);
            check("wr_ready", wr_ready, ph == 1 && path_available);
            check("busy", busy, ph != 0);
            check("done", done, ph == 3);
            check("error", error, e_err);
            check("done_error_excl", done && error, 0);
            check("update_en", update_en, e_en);
            check("update_axis", update_axis, e_ax);
            check("update_bank", update_bank, e_bk);
            check("update_index", update_index, e_ix);
            check("update_value", update_value, e_val);
            check("x_bank", x_bank, banks[1]);
            check("y_bank", y_bank, banks[2]);
            check("z_bank", z_bank, banks[3]);
        end
        model_step();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic fix_cmd(input int ax, input int bk, input int act);
        g_fix = 1; g_fax = ax; g_fbk = bk; g_fact = act;
    endtask

    initial begin
        cyc = 0;
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_axis = 2'd0; cmd_bank = 2'd0; cmd_activate = 1'b0;
        wr_valid = 1'b0; wr_data = 16'd0; path_available = 1'b0;
        g_cv_pct = 0; g_wv_pct = 0; g_pa_mode = 1; g_fix = 1; g_fax = 0; g_fbk = 0; g_fact = 0;
        g_seq = 0; g_rst_at7 = 0; g_rand_rst = 0;
        model_reset();
        @(posedge sys_clk);

        // Full-speed load of x bank 2, sequential words, no activate
        fix_cmd(1, 2, 0); g_seq = 1; g_wv_pct = 100; g_pa_mode = 1;
        g_cv_pct = 100; run(1);
        g_cv_pct = 0;   run(22);

        // z bank 1 with activate while the path stays busy for 20 cycles
        fix_cmd(3, 1, 1); g_pa_mode = 3;
        g_cv_pct = 100; run(1);
        g_cv_pct = 0;   run(60);

        // Rejects: illegal axis, then the bank y is already using
        fix_cmd(0, 0, 0); g_cv_pct = 100; run(3);
        fix_cmd(2, 0, 0); run(3);

        // Back-pressure: path_available toggles every cycle
        fix_cmd(2, 3, 1); g_pa_mode = 2; g_wv_pct = 100;
        g_cv_pct = 100; run(1);
        g_cv_pct = 0;   run(60);

        // Reset at beat 7, then a new command straight after
        fix_cmd(1, 3, 0); g_pa_mode = 1; g_rst_at7 = 1; g_cv_pct = 100;
        run(40);
        g_cv_pct = 0; run(5);

        // Random traffic with occasional resets
        g_fix = 0; g_seq = 0; g_pa_mode = 0; g_cv_pct = 30; g_wv_pct = 70; g_rand_rst = 1;
        run(4000);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
